// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU pipeline-control blocks.
//   md_op_e          E-stage multiply/divide start encoding
//   tmr_state_e      state of the multiply/divide busy timer
//   MULT_CYCLES_DEF  default busy length after a mult/multu start
//   DIV_CYCLES_DEF   default busy length after a div/divu start
//   PC_RESET         PC value after reset (used by neighbouring blocks)
package cpu_pkg;

    typedef enum logic [1:0] {
        MD_OP_NONE = 2'b00,
        MD_OP_MULT = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_RSVD = 2'b11
    } md_op_e;

    typedef enum logic {
        TMR_IDLE,
        TMR_BUSY
    } tmr_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam logic [31:0] PC_RESET        = 32'h0000_3000;

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: occupancy timer for the multiply/divide unit.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   md_op       E-stage MD start request (md_op_e encoding)
//   md_start    a start is accepted this cycle (valid op while idle)
//   md_busy     timer running (registered)
//   md_done     last busy cycle
import cpu_pkg::*;

module md_busy_timer #(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] md_op,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY always coincides with cnt != 0; a request seen while BUSY is
    // dropped without reloading the count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        unique case (state_q)
            TMR_IDLE: begin
                if (md_op == MD_OP_MULT) begin
                    md_start = 1'b1;
                    cnt_d    = MULT_LOAD;
                    state_d  = TMR_BUSY;
                end else if (md_op == MD_OP_DIV) begin
                    md_start = 1'b1;
                    cnt_d    = DIV_LOAD;
                    state_d  = TMR_BUSY;
                end
            end
            TMR_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = TMR_IDLE;
                end
            end
            default: begin
                state_d = TMR_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == TMR_BUSY);
    assign md_done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller for the five-stage CPU.
// Combines the data-hazard request with multiply/divide occupancy into one
// stall decision per cycle and drives the PC / pipeline register controls.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   raw_stall     data-hazard stall request (combinational, same cycle)
//   e_md_op       E-stage MD start (00 none, 01 mult, 10 div, 11 ignored)
//   d_md_use      D-stage instruction needs the MD unit
//   pc_en         PC write enable
//   fd_en         F/D register enable
//   de_clr        D/E register synchronous clear (bubble)
//   md_busy       MD timer running
//   md_done       last MD busy cycle
//   stall_cycles  saturating count of stalled cycles
import cpu_pkg::*;

module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw_stall,
    input  logic [1:0]  e_md_op,
    input  logic        d_md_use,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    logic        md_start;
    logic        stall;
    logic [31:0] stall_cnt_q;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .md_op    (e_md_op),
        .md_start (md_start),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    // An MD consumer in D waits both in the start cycle and while busy.
    assign stall  = raw_stall | (d_md_use & (md_start | md_busy));
    assign pc_en  = ~stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed self-checking bench for stall_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 ns later,
// i.e. well before the next rising edge.
`timescale 1ns/1ps
module tb_stall_ctrl;

    logic        clk;
    logic        reset;
    logic        raw_stall;
    logic [1:0]  e_md_op;
    logic        d_md_use;
    logic        pc_en;
    logic        fd_en;
    logic        de_clr;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    int checks = 0;
    int fails  = 0;
    int viol   = 0;

    stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_stall    (raw_stall),
        .e_md_op      (e_md_op),
        .d_md_use     (d_md_use),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_clr       (de_clr),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: an MD start presented while the unit is busy.
    always @(posedge clk) begin
        if (!reset && md_busy && (e_md_op == 2'b01 || e_md_op == 2'b10))
            viol++;
    end

    task automatic step(input logic rst, input logic [1:0] op,
                        input logic use_md, input logic raw);
        @(negedge clk);
        reset     = rst;
        e_md_op   = op;
        d_md_use  = use_md;
        raw_stall = raw;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({md_busy, md_done, pc_en, fd_en, de_clr} !== 5'b00110) begin
            fails++;
            $display("FAIL reset_outputs: got busy/done/pc/fd/clr=%b expected 00110",
                     {md_busy, md_done, pc_en, fd_en, de_clr});
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_count: got %h expected 00000000", stall_cycles);
        end
        // Start a mult, let it stall twice, then reset in busy cycle 2.
        step(1'b0, 2'b01, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        checks++;
        if (md_busy !== 1'b1 || stall_cycles !== 32'd2) begin
            fails++;
            $display("FAIL reset_precond: got busy=%b cnt=%0d expected busy=1 cnt=2",
                     md_busy, stall_cycles);
        end
        step(1'b1, 2'b00, 1'b0, 1'b0);
        checks++;
        if (md_busy !== 1'b0 || pc_en !== 1'b1 || de_clr !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_reset: got busy=%b pc_en=%b de_clr=%b expected 0 1 0",
                     md_busy, pc_en, de_clr);
        end
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        checks++;
        if (md_busy !== 1'b0 || stall_cycles !== 32'd0 || pc_en !== 1'b1 || md_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy: got busy=%b done=%b cnt=%0d pc_en=%b expected 0 0 0 1",
                     md_busy, md_done, stall_cycles, pc_en);
        end
    endtask

    task automatic test_mult();
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            step(1'b0, (k == 0) ? 2'b01 : 2'b00, 1'b1, 1'b0);
            checks++;
            if (md_busy !== (k >= 1 && k <= 5) || md_done !== (k == 5) ||
                pc_en !== (k == 6) || fd_en !== (k == 6) || de_clr !== (k != 6)) begin
                fails++;
                $display("FAIL mult_k%0d: got busy=%b done=%b pc=%b fd=%b clr=%b expected %b %b %b %b %b",
                         k, md_busy, md_done, pc_en, fd_en, de_clr,
                         (k >= 1 && k <= 5), (k == 5), (k == 6), (k == 6), (k != 6));
            end
            checks++;
            if (stall_cycles !== 32'(k)) begin
                fails++;
                $display("FAIL mult_count_k%0d: got %0d expected %0d", k, stall_cycles, k);
            end
        end
    endtask

    task automatic test_div_no_use();
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            step(1'b0, (k == 0) ? 2'b10 : 2'b00, 1'b0, 1'b0);
            checks++;
            if (md_busy !== (k >= 1 && k <= 10) || md_done !== (k == 10) || pc_en !== 1'b1) begin
                fails++;
                $display("FAIL div_k%0d: got busy=%b done=%b pc=%b expected %b %b 1",
                         k, md_busy, md_done, pc_en, (k >= 1 && k <= 10), (k == 10));
            end
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL div_count: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_raw_overlap();
        int exp_cnt;
        logic exp_clr;
        do_reset();
        exp_cnt = 0;
        // mult busy 1..5; d_md_use from 4; raw_stall 3..5 -> stalls 3,4,5
        for (int k = 0; k <= 7; k++) begin
            step(1'b0, (k == 0) ? 2'b01 : 2'b00, k >= 4, (k >= 3 && k <= 5));
            exp_clr = (k >= 3 && k <= 5);
            checks++;
            if (de_clr !== exp_clr || pc_en !== !exp_clr || stall_cycles !== 32'(exp_cnt)) begin
                fails++;
                $display("FAIL overlap_k%0d: got clr=%b pc=%b cnt=%0d expected %b %b %0d",
                         k, de_clr, pc_en, stall_cycles, exp_clr, !exp_clr, exp_cnt);
            end
            if (exp_clr) exp_cnt++;
        end
        checks++;
        if (stall_cycles !== 32'd3) begin
            fails++;
            $display("FAIL overlap_total: got %0d expected 3", stall_cycles);
        end
    endtask

    task automatic test_ignored_start();
        int v0;
        logic [1:0] op;
        do_reset();
        v0 = viol;
        for (int k = 0; k <= 7; k++) begin
            op = (k == 0) ? 2'b01 : (k == 2) ? 2'b10 : (k == 6) ? 2'b11 : 2'b00;
            step(1'b0, op, 1'b0, 1'b0);
            checks++;
            if (md_busy !== (k >= 1 && k <= 5) || md_done !== (k == 5)) begin
                fails++;
                $display("FAIL ignored_k%0d: got busy=%b done=%b expected %b %b",
                         k, md_busy, md_done, (k >= 1 && k <= 5), (k == 5));
            end
        end
        checks++;
        if (viol - v0 !== 1) begin
            fails++;
            $display("FAIL busy_start_flag: got %0d violations expected 1", viol - v0);
        end
    endtask

    task automatic test_back_to_back();
        logic eb;
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            step(1'b0, (k == 0 || k == 6) ? 2'b01 : 2'b00, 1'b1, 1'b0);
            eb = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
            checks++;
            if (md_busy !== eb || md_done !== (k == 5 || k == 11) ||
                pc_en !== (k == 12) || stall_cycles !== 32'(k)) begin
                fails++;
                $display("FAIL b2b_k%0d: got busy=%b done=%b pc=%b cnt=%0d expected %b %b %b %0d",
                         k, md_busy, md_done, pc_en, stall_cycles,
                         eb, (k == 5 || k == 11), (k == 12), k);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_sat [0:4];
        exp_sat[0] = 32'hFFFF_FFFD;
        exp_sat[1] = 32'hFFFF_FFFE;
        exp_sat[2] = 32'hFFFF_FFFF;
        exp_sat[3] = 32'hFFFF_FFFF;
        exp_sat[4] = 32'hFFFF_FFFF;
        do_reset();
        @(posedge clk);
        #2;
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        for (int k = 0; k <= 4; k++) begin
            step(1'b0, 2'b00, 1'b0, k <= 3);
            checks++;
            if (stall_cycles !== exp_sat[k]) begin
                fails++;
                $display("FAIL sat_k%0d: got %h expected %h", k, stall_cycles, exp_sat[k]);
            end
        end
        do_reset();
        checks++;
        if (stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL sat_reset: got %h expected 00000000", stall_cycles);
        end
    endtask

    initial begin
        reset     = 1'b1;
        raw_stall = 1'b0;
        e_md_op   = 2'b00;
        d_md_use  = 1'b0;
        test_reset();
        test_mult();
        test_div_no_use();
        test_raw_overlap();
        test_ignored_start();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/flush controller for the five-stage CPU. Owns the multiply/divide busy timer. Combines the upstream data-hazard request and MD-unit occupancy into one stall decision per cycle. From that decision it drives the PC write enable, the F/D register enable and the D/E register clear. It sits beside the PC and pipeline registers and is their only source of enable/clear.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- CNT_W, 4, timer width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- raw_stall  in  1  data-hazard stall request from the Tuse/Tnew comparator (combinational, same cycle)
- e_md_op  in  2  E-stage MD start: 00 none, 01 mult class, 10 div class, 11 reserved (treated as none)
- d_md_use  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- pc_en  out  1  PC write enable
- fd_en  out  1  F/D register enable
- de_clr  out  1  D/E register synchronous clear (bubble insert)
- md_busy  out  1  MD timer running
- md_done  out  1  one-cycle pulse in last busy cycle
- stall_cycles  out  32  count of cycles with stall asserted, saturating

## Operation
- stall = raw_stall | (d_md_use & (md_start | md_busy)), where md_start = (e_md_op == 01 | e_md_op == 10) & ~md_busy.
- pc_en = fd_en = ~stall; de_clr = stall. All three are combinational from inputs and state.
- Timer FSM:
  - IDLE (cnt == 0): on md_start, load cnt with MULT_CYCLES (01) or DIV_CYCLES (10), go to BUSY.
  - BUSY (cnt != 0): decrement each cycle. Return to IDLE when cnt reaches 0.
- md_busy = (cnt != 0), registered state. md_done = (cnt == 1).
- A start while BUSY is ignored: cnt is not reloaded. This is legal only as a protocol violation and must be flagged by the bench assertion.
- e_md_op == 11 never starts the timer.
- stall_cycles increments by 1 in every cycle where stall = 1. It holds at 32'hFFFF_FFFF.
- Reset, including mid-BUSY: cnt = 0, stall_cycles = 0. Outputs follow the reset values below from the next cycle.

## Timing
- Reset values: md_busy 0, md_done 0, stall_cycles 0. With raw_stall = d_md_use = 0 during reset: pc_en 1, fd_en 1, de_clr 0.
- Start in cycle T sets md_busy high in cycles T+1 through T+N, where N = MULT_CYCLES or DIV_CYCLES. md_done is high in cycle T+N. A new start is accepted at the earliest in cycle T+N+1.
- A D-stage MD instruction is stalled in cycle T (start visible) and in every busy cycle. It advances in cycle T+N+1.
- Back-to-back: start at T+N+1 is accepted and loads a fresh count.
- raw_stall and the MD condition together produce one stall. There is no double counting in stall_cycles.
- No output depends on reset combinationally. reset acts only through the state.

## Structure
- Shared package (cpu_pkg): MD_OP_NONE/MULT/DIV/RSVD encodings, MULT_CYCLES/DIV_CYCLES defaults, PC_RESET = 32'h3000 for neighbouring blocks.
- Sub-module md_busy_timer holds cnt, the load/decrement logic, md_busy and md_done. stall_ctrl instantiates it and adds the stall combine and the stall_cycles counter.

## Test plan
- Reset held 3 cycles with cnt mid-count (inject start, then reset at busy cycle 2) -> md_busy 0, stall_cycles 0, pc_en 1 on the first post-reset cycle.
- e_md_op = 01 at T, d_md_use = 1 throughout -> md_busy high T+1..T+5, md_done at T+5, pc_en low T..T+5, high T+6, stall_cycles = 6.
- e_md_op = 10 at T, d_md_use = 0 -> pc_en stays 1, md_busy high T+1..T+10, md_done at T+10, stall_cycles = 0.
- raw_stall = 1 for 3 cycles overlapping 2 MD busy cycles with d_md_use = 1 -> de_clr high on the union of those cycles, counter increments once per cycle.
- e_md_op = 01 at T, e_md_op = 10 at T+2 -> ignored, md_done still at T+5. Then e_md_op = 11 at T+6 -> no start, md_busy 0.
- Preload stall_cycles near saturation via forced stall -> reaches 32'hFFFF_FFFF and holds.
